output_quant_fifo: RTL
======================

# output_quant_fifo

Parametrised output stage between the convolution datapath and the external connection bus of `top_system`. It accepts accumulated results tagged with (x, y, channel) and requantises each one from `ACCUMULATION_WIDTH` to `IO_DATA_WIDTH` by arithmetic shift and optional saturation. Results are buffered in a FIFO and streamed out under valid/ready backpressure. A frame-level state machine counts results against the configured feature-map volume and signals completion once the FIFO has drained.

## Interface
- `IO_DATA_WIDTH`, 16, output sample width.
- `ACCUMULATION_WIDTH`, 32, input accumulator width (must be greater than `IO_DATA_WIDTH`).
- `FEATURE_MAP_WIDTH`, 64, x extent; `XW = $clog2(FEATURE_MAP_WIDTH)`.
- `FEATURE_MAP_HEIGHT`, 64, y extent; `YW = $clog2(FEATURE_MAP_HEIGHT)`.
- `OUTPUT_NB_CHANNELS`, 32, channel extent; `CW = $clog2(OUTPUT_NB_CHANNELS)`.
- `FIFO_DEPTH`, 8, entries; must be a power of two and at least 2.
- `OUT_SHIFT`, 0, arithmetic right shift applied before narrowing; range 0..`ACCUMULATION_WIDTH-IO_DATA_WIDTH`.
- `clk`  in  1  single clock, rising edge.
- `rst_in`  in  1  synchronous, active-high reset.
- `start`  in  1  frame start; sampled only in IDLE.
- `in_valid`  in  1  input sample valid.
- `in_ready`  out  1  input sample accepted when high together with `in_valid`.
- `in_data`  in  `ACCUMULATION_WIDTH`  signed accumulator value.
- `in_x` / `in_y` / `in_ch`  in  XW / YW / CW  coordinate tags.
- `out_valid`  out  1  output sample valid.
- `out_ready`  in  1  downstream accepts the sample.
- `out_data`  out  `IO_DATA_WIDTH`  requantised signed sample.
- `out_x` / `out_y` / `out_ch`  out  XW / YW / CW  tags of `out_data`.
- `running`  out  1  high in RUN and DRAIN.
- `done`  out  1  one-cycle pulse at frame completion.
- `fill_level`  out  `$clog2(FIFO_DEPTH)+1`  current FIFO occupancy.

## Operation
- `TOTAL = FEATURE_MAP_WIDTH*FEATURE_MAP_HEIGHT*OUTPUT_NB_CHANNELS`.
- The accepted-sample counter is `$clog2(TOTAL+1)` bits wide.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE → RUN when `start`=1; the counter clears.
  - RUN → DRAIN on the cycle the `TOTAL`-th input handshake occurs.
  - DRAIN → IDLE when the FIFO is empty; `done` pulses in that transition cycle.
  - `start` is ignored in RUN and DRAIN.
- `in_ready = (state==RUN) && (fill_level < FIFO_DEPTH)`.
  - There is no bypass: a full FIFO does not accept, even if a pop occurs in the same cycle.
- Requantisation is applied on the push side, and only the narrow value is stored:
  - `s = in_data >>> OUT_SHIFT` (sign-preserving arithmetic shift).
  - `s` is then narrowed per the Configuration section.
- Tags pass through unchanged and stay aligned with their data.
- Ordering is strict FIFO.
- Push and pop in the same cycle leave `fill_level` unchanged.
- A pop is `out_valid && out_ready`. `out_valid = (fill_level != 0)`.
- Pointers wrap modulo `FIFO_DEPTH`; no entry is lost or duplicated across the wrap.
- In-order inputs are not checked; tags are carried, not validated.

## Timing
- Write-to-read latency is 1 cycle: a sample accepted at edge N is presented with `out_valid`=1 after edge N.
- The FIFO is registered; there is no combinational path from `in_valid` to `out_valid`.
- Throughput is 1 sample per cycle while `out_ready`=1 and the FIFO is not full.
- Upon edge N+1 after the `TOTAL`-th handshake at edge N, `in_ready`=0.
- `done` is asserted for exactly one cycle, in the cycle after the last pop empties the FIFO in DRAIN.
  - `running` falls in the same cycle.
- `out_data` and tags hold stable while `out_valid`=1 and `out_ready`=0.
- Reset values (`rst_in`=1 at any edge, including mid-frame):
  - State IDLE; FIFO emptied.
  - `in_ready`=0, `out_valid`=0, `out_data`/`out_x`/`out_y`/`out_ch`=0.
  - `running`=0, `done`=0, `fill_level`=0, counter=0.
  - After reset, a new `start` is required.

## Configuration
- Macro: `OUTPUT_QUANT_SATURATE_EN`.
- Defined: `s` is clamped to [-2^(IO_DATA_WIDTH-1), 2^(IO_DATA_WIDTH-1)-1] before narrowing.
- Undefined: the low `IO_DATA_WIDTH` bits of `s` are taken (two's-complement wrap); no clamp logic is instantiated.

## Test plan
- Default params, `OUT_SHIFT`=0. Push `in_data`=0x0001_0000, then 0xFFFF_0000, then 0x0000_1234.
  - With macro: `out_data`=0x7FFF, 0x8000, 0x1234.
  - Without macro: 0x0000, 0x0000, 0x1234.
- `OUT_SHIFT`=4. Push 0x0000_0123 and 0xFFFF_FFE0 → `out_data`=0x0012 and 0xFFFE.
- `FIFO_DEPTH`=4, `out_ready`=0, continuous `in_valid`:
  - Exactly 4 accepts, then `in_ready`=0 and `fill_level`=4.
  - Raise `out_ready`: 4 pops in push order, with tags intact.
- Frame of 2×2×2 (`TOTAL`=8), `out_ready`=1 throughout:
  - 8 accepts; `in_ready`=0 from the cycle after the 8th.
  - `done` is a single pulse one cycle after the 8th pop; `running`=0.
  - `start` pulsed during RUN has no effect.
- `fill_level`=2 with simultaneous push and pop for 10 cycles → `fill_level` stays 2, pointers wrap, and output order is preserved.
- Reset mid-frame: after 3 pushes with `out_ready`=0, assert `rst_in` for 1 cycle.
  - Next cycle: `out_valid`=0, `fill_level`=0, `running`=0.
  - `in_valid` is not accepted until a new `start`.

Source files
------------

// File: rtl/output_quant_fifo.sv
// output_quant_fifo: requantising output FIFO with frame FSM; define OUTPUT_QUANT_SATURATE_EN to clamp instead of wrap
module output_quant_fifo #(
    parameter int IO_DATA_WIDTH      = 16,
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int FEATURE_MAP_WIDTH  = 64,
    parameter int FEATURE_MAP_HEIGHT = 64,
    parameter int OUTPUT_NB_CHANNELS = 32,
    parameter int FIFO_DEPTH         = 8,
    parameter int OUT_SHIFT          = 0,
    localparam int XW = $clog2(FEATURE_MAP_WIDTH),
    localparam int YW = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CW = $clog2(OUTPUT_NB_CHANNELS),
    localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_in,
    input  logic                                 start,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic [XW-1:0]                        in_x,
    input  logic [YW-1:0]                        in_y,
    input  logic [CW-1:0]                        in_ch,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [IO_DATA_WIDTH-1:0]             out_data,
    output logic [XW-1:0]                        out_x,
    output logic [YW-1:0]                        out_y,
    output logic [CW-1:0]                        out_ch,
    output logic                                 running,
    output logic                                 done,
    output logic [LW-1:0]                        fill_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;
    localparam int NW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                   state;
    logic [NW-1:0]            cnt;
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [IO_DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [XW-1:0]            mem_x [FIFO_DEPTH];
    logic [YW-1:0]            mem_y [FIFO_DEPTH];
    logic [CW-1:0]            mem_c [FIFO_DEPTH];
    logic                     push, pop;
    logic [LW-1:0]            fill_nxt;
    logic [IO_DATA_WIDTH-1:0] q;

`ifdef OUTPUT_QUANT_SATURATE_EN
    localparam logic signed [ACCUMULATION_WIDTH-1:0] QMAX =
        {{(ACCUMULATION_WIDTH-IO_DATA_WIDTH+1){1'b0}}, {(IO_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACCUMULATION_WIDTH-1:0] QMIN =
        {{(ACCUMULATION_WIDTH-IO_DATA_WIDTH+1){1'b1}}, {(IO_DATA_WIDTH-1){1'b0}}};
    logic signed [ACCUMULATION_WIDTH-1:0] shifted;
    assign shifted = in_data >>> OUT_SHIFT;
    assign q = shifted > QMAX ? QMAX[IO_DATA_WIDTH-1:0] :
               shifted < QMIN ? QMIN[IO_DATA_WIDTH-1:0] : shifted[IO_DATA_WIDTH-1:0];
`else
    assign q = IO_DATA_WIDTH'(in_data >>> OUT_SHIFT);
`endif

    // no bypass: a full FIFO refuses input even when it is popped in the same cycle
    assign in_ready  = state == RUN && fill_level < LW'(FIFO_DEPTH);
    assign out_valid = fill_level != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign fill_nxt  = fill_level + LW'(push) - LW'(pop);
    assign running   = state != IDLE;
    assign out_data  = out_valid ? mem_d[rd_ptr] : '0;
    assign out_x     = out_valid ? mem_x[rd_ptr] : '0;
    assign out_y     = out_valid ? mem_y[rd_ptr] : '0;
    assign out_ch    = out_valid ? mem_c[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_d[wr_ptr] <= q;
            mem_x[wr_ptr] <= in_x;
            mem_y[wr_ptr] <= in_y;
            mem_c[wr_ptr] <= in_ch;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            done       <= 1'b0;
        end else begin
            fill_level <= fill_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                cnt    <= cnt + NW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            // done and the fall of running share the edge on which the FIFO empties in DRAIN
            done <= state == DRAIN && fill_nxt == '0;
            case (state)
                IDLE: if (start) begin
                    state <= RUN;
                    cnt   <= '0;
                end
                RUN:     if (push && cnt == NW'(TOTAL - 1)) state <= DRAIN;
                DRAIN:   if (fill_nxt == '0) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
